// File: rtl/ifu_ift2mem_pkg.sv
// Shared types and constants for the IFU fetch-to-instruction-memory bridge.
// FSM encodings, instruction/bus widths, the fault NOP and the bus OKAY response code.
package ifu_ift2mem_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int ST_W    = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } ift2mem_st_e;

    localparam logic [INSTR_W-1:0] INSTR_NOP     = 32'h0000_0013;
    localparam logic [1:0]         MEM_RESP_OKAY = 2'b00;

    function automatic logic pc_aligned(input logic [PC_W-1:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_ift2mem_if.sv
// Fetch request/response channels plus the instruction-memory AR/R read bus.
// slave = the bridge's view; master = the fetch unit and memory side driving it.
interface ifu_ift2mem_if;
    import ifu_ift2mem_pkg::*;

    logic               ifu_req_valid;
    logic               ifu_req_ready;
    logic [PC_W-1:0]    ifu_req_pc;
    logic               ifu_rsp_valid;
    logic               ifu_rsp_ready;
    logic [INSTR_W-1:0] ifu_rsp_instr;
    logic               ifu_rsp_err;
    logic               mem_arvalid;
    logic               mem_arready;
    logic [PC_W-1:0]    mem_araddr;
    logic               mem_rvalid;
    logic               mem_rready;
    logic [INSTR_W-1:0] mem_rdata;
    logic [1:0]         mem_rresp;

    modport slave (
        input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
        input  mem_arready, mem_rvalid, mem_rdata, mem_rresp,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err,
        output mem_arvalid, mem_araddr, mem_rready
    );

    modport master (
        output ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
        output mem_arready, mem_rvalid, mem_rdata, mem_rresp,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err,
        input  mem_arvalid, mem_araddr, mem_rready
    );

endinterface

// File: rtl/ifu_ift2mem_dfflr.sv
// Generic load-enabled flop bank with synchronous active-high reset to zero.
// Latency 1 cycle; holds its value whenever lden is low.
module ifu_ift2mem_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/ifu_ift2mem.sv
// Bridges one IFU fetch PC to a single AR/R instruction read and returns instr + fault.
// Latency: 3 cycles request-to-response on a zero-wait bus, 1 cycle for a misaligned fault.
// Backpressure: one read outstanding; a 1-entry pend buffer absorbs a request while a response is held.
module ifu_ift2mem
    import ifu_ift2mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ifu_ift2mem_if.slave      bus
);

    logic [ST_W-1:0]    state_q;
    ift2mem_st_e        state_r;
    ift2mem_st_e        state_nxt;
    logic               state_ena;

    logic [PC_W-1:0]    addr_r;
    logic [PC_W-1:0]    addr_nxt;
    logic               addr_ena;

    logic               pend_vld_r;
    logic               pend_vld_nxt;
    logic [PC_W-1:0]    pend_addr_r;
    logic               pend_ena;

    logic [INSTR_W-1:0] instr_r;
    logic [INSTR_W-1:0] instr_nxt;
    logic               err_r;
    logic               err_nxt;
    logic               data_ena;

    logic               req_hsk;
    logic               rsp_hsk;
    logic               issue;
    logic [PC_W-1:0]    issue_pc;
    logic               rresp_err;

    assign state_r = ift2mem_st_e'(state_q);

    // Both ready and valid come only from registered state, so the fetch
    // unit can safely tie rsp_ready to req_ready without forming a loop.
    assign bus.ifu_req_ready = (state_r == ST_IDLE) | ((state_r == ST_HOLD) & ~pend_vld_r);
    assign bus.ifu_rsp_valid = (state_r == ST_HOLD);
    assign bus.ifu_rsp_instr = instr_r;
    assign bus.ifu_rsp_err   = err_r;
    assign bus.mem_arvalid   = (state_r == ST_ADDR);
    assign bus.mem_araddr    = addr_r;
    assign bus.mem_rready    = (state_r == ST_DATA);

    assign req_hsk   = bus.ifu_req_valid & bus.ifu_req_ready;
    assign rsp_hsk   = bus.ifu_rsp_valid & bus.ifu_rsp_ready;
    assign issue_pc  = pend_vld_r ? pend_addr_r : bus.ifu_req_pc;
    assign rresp_err = (bus.mem_rresp != MEM_RESP_OKAY);

    always_comb begin
        state_nxt    = state_r;
        state_ena    = 1'b0;
        addr_nxt     = {issue_pc[PC_W-1:2], 2'b00};
        addr_ena     = 1'b0;
        pend_vld_nxt = pend_vld_r;
        pend_ena     = 1'b0;
        instr_nxt    = INSTR_NOP;
        err_nxt      = 1'b1;
        data_ena     = 1'b0;
        issue        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                issue = req_hsk;
            end
            ST_ADDR: begin
                if (bus.mem_arready) begin
                    state_ena = 1'b1;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.mem_rvalid) begin
                    state_ena = 1'b1;
                    state_nxt = ST_HOLD;
                    data_ena  = 1'b1;
                    err_nxt   = rresp_err;
                    instr_nxt = rresp_err ? INSTR_NOP : bus.mem_rdata;
                end
            end
            ST_HOLD: begin
                if (rsp_hsk) begin
                    // Pending entry has priority; a new request cannot also
                    // handshake because req_ready is low while pend is full.
                    if (pend_vld_r | req_hsk) begin
                        issue = 1'b1;
                    end else begin
                        state_ena = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                    if (pend_vld_r) begin
                        pend_ena     = 1'b1;
                        pend_vld_nxt = 1'b0;
                    end
                end else if (req_hsk) begin
                    pend_ena     = 1'b1;
                    pend_vld_nxt = 1'b1;
                end
            end
            default: begin
                state_ena = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase

        if (issue) begin
            state_ena = 1'b1;
            if (pc_aligned(issue_pc)) begin
                state_nxt = ST_ADDR;
                addr_ena  = 1'b1;
            end else begin
                state_nxt = ST_HOLD;
                data_ena  = 1'b1;
                instr_nxt = INSTR_NOP;
                err_nxt   = 1'b1;
            end
        end
    end

    ifu_ift2mem_dfflr #(.DW(ST_W)) u_state_dff (
        .clk  (clk),
        .rst  (rst),
        .lden (state_ena),
        .dnxt (state_nxt),
        .qout (state_q)
    );

    ifu_ift2mem_dfflr #(.DW(PC_W)) u_addr_dff (
        .clk  (clk),
        .rst  (rst),
        .lden (addr_ena),
        .dnxt (addr_nxt),
        .qout (addr_r)
    );

    ifu_ift2mem_dfflr #(.DW(1)) u_pend_vld_dff (
        .clk  (clk),
        .rst  (rst),
        .lden (pend_ena),
        .dnxt (pend_vld_nxt),
        .qout (pend_vld_r)
    );

    ifu_ift2mem_dfflr #(.DW(PC_W)) u_pend_addr_dff (
        .clk  (clk),
        .rst  (rst),
        .lden (pend_ena),
        .dnxt (bus.ifu_req_pc),
        .qout (pend_addr_r)
    );

    ifu_ift2mem_dfflr #(.DW(INSTR_W)) u_instr_dff (
        .clk  (clk),
        .rst  (rst),
        .lden (data_ena),
        .dnxt (instr_nxt),
        .qout (instr_r)
    );

    ifu_ift2mem_dfflr #(.DW(1)) u_err_dff (
        .clk  (clk),
        .rst  (rst),
        .lden (data_ena),
        .dnxt (err_nxt),
        .qout (err_r)
    );

endmodule

// File: tb/tb_ifu_ift2mem.sv
// Directed bench for ifu_ift2mem: drives fetch/memory channels 1ns after each rising edge
// and checks register-driven outputs at that point against hand-computed values.
module tb_ifu_ift2mem;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ifu_ift2mem_if bus ();

    ifu_ift2mem u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req_ready"}, 32'(bus.ifu_req_ready), 32'd1);
        chk({tag, ".rsp_valid"}, 32'(bus.ifu_rsp_valid), 32'd0);
        chk({tag, ".rsp_err"},   32'(bus.ifu_rsp_err),   32'd0);
        chk({tag, ".rsp_instr"}, bus.ifu_rsp_instr,      32'd0);
        chk({tag, ".arvalid"},   32'(bus.mem_arvalid),   32'd0);
        chk({tag, ".rready"},    32'(bus.mem_rready),    32'd0);
        chk({tag, ".araddr"},    bus.mem_araddr,         32'd0);
    endtask

    initial begin
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_pc    = '0;
        bus.ifu_rsp_ready = 1'b0;
        bus.mem_arready   = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
        bus.mem_rresp     = 2'b00;

        tick();
        tick();
        rst = 1'b0;
        chk_reset_outputs("rst");

        // 1: zero-wait aligned fetch, response three cycles after the request
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h8000_0000;
        bus.mem_arready   = 1'b1;
        bus.mem_rvalid    = 1'b1;
        bus.mem_rdata     = 32'h0010_0093;
        tick();
        bus.ifu_req_valid = 1'b0;
        chk("t1.arvalid",   32'(bus.mem_arvalid),   32'd1);
        chk("t1.araddr",    bus.mem_araddr,         32'h8000_0000);
        chk("t1.req_ready", 32'(bus.ifu_req_ready), 32'd0);
        tick();
        chk("t1.rready",    32'(bus.mem_rready),    32'd1);
        chk("t1.rsp_T2",    32'(bus.ifu_rsp_valid), 32'd0);
        tick();
        chk("t1.rsp_T3",    32'(bus.ifu_rsp_valid), 32'd1);
        chk("t1.instr",     bus.ifu_rsp_instr,      32'h0010_0093);
        chk("t1.err",       32'(bus.ifu_rsp_err),   32'd0);
        bus.ifu_rsp_ready = 1'b1;
        tick();
        bus.ifu_rsp_ready = 1'b0;
        chk("t1.idle_rsp",  32'(bus.ifu_rsp_valid), 32'd0);
        chk("t1.idle_rdy",  32'(bus.ifu_req_ready), 32'd1);

        // 2: arready withheld for five cycles
        bus.mem_arready   = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h8000_0010;
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_pc    = 32'h1234_5670;
        for (int i = 0; i < 5; i++) begin
            chk("t2.arvalid",   32'(bus.mem_arvalid),   32'd1);
            chk("t2.araddr",    bus.mem_araddr,         32'h8000_0010);
            chk("t2.req_ready", 32'(bus.ifu_req_ready), 32'd0);
            tick();
        end
        chk("t2.arvalid_last", 32'(bus.mem_arvalid), 32'd1);
        bus.mem_arready = 1'b1;
        bus.mem_rvalid  = 1'b1;
        bus.mem_rdata   = 32'hDEAD_BEEF;
        tick();
        chk("t2.rready",     32'(bus.mem_rready),    32'd1);
        chk("t2.req_ready",  32'(bus.ifu_req_ready), 32'd0);
        tick();
        chk("t2.rsp_valid",  32'(bus.ifu_rsp_valid), 32'd1);
        chk("t2.instr",      bus.ifu_rsp_instr,      32'hDEAD_BEEF);
        chk("t2.hold_ready", 32'(bus.ifu_req_ready), 32'd1);
        bus.ifu_rsp_ready = 1'b1;
        tick();
        bus.ifu_rsp_ready = 1'b0;

        // 3: bus error response
        bus.mem_rresp     = 2'b10;
        bus.mem_rdata     = 32'h1234_5678;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h8000_0020;
        tick();
        bus.ifu_req_valid = 1'b0;
        tick();
        tick();
        chk("t3.rsp_valid", 32'(bus.ifu_rsp_valid), 32'd1);
        chk("t3.err",       32'(bus.ifu_rsp_err),   32'd1);
        chk("t3.instr",     bus.ifu_rsp_instr,      32'h0000_0013);
        bus.ifu_rsp_ready = 1'b1;
        tick();
        bus.ifu_rsp_ready = 1'b0;
        bus.mem_rresp     = 2'b00;

        // 4: misaligned PC faults without touching the bus
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h8000_0002;
        tick();
        bus.ifu_req_valid = 1'b0;
        chk("t4.arvalid",   32'(bus.mem_arvalid),   32'd0);
        chk("t4.rsp_valid", 32'(bus.ifu_rsp_valid), 32'd1);
        chk("t4.err",       32'(bus.ifu_rsp_err),   32'd1);
        chk("t4.instr",     bus.ifu_rsp_instr,      32'h0000_0013);
        bus.ifu_rsp_ready = 1'b1;
        tick();
        bus.ifu_rsp_ready = 1'b0;
        chk("t4.idle", 32'(bus.ifu_req_ready), 32'd1);

        // 5: pending buffer, then same-cycle request + response handshakes
        bus.mem_rdata     = 32'h1111_1111;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h8000_0008;
        tick();
        bus.ifu_req_valid = 1'b0;
        tick();
        tick();
        chk("t5.hold_rsp",  32'(bus.ifu_rsp_valid), 32'd1);
        chk("t5.hold_rdy",  32'(bus.ifu_req_ready), 32'd1);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h8000_0004;
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_pc    = 32'h0;
        chk("t5.pend_rdy",  32'(bus.ifu_req_ready), 32'd0);
        chk("t5.pend_rsp",  32'(bus.ifu_rsp_valid), 32'd1);
        chk("t5.pend_ins",  bus.ifu_rsp_instr,      32'h1111_1111);
        bus.ifu_rsp_ready = 1'b1;
        bus.mem_rdata     = 32'h2222_2222;
        tick();
        bus.ifu_rsp_ready = 1'b0;
        chk("t5.pend_arv",  32'(bus.mem_arvalid),   32'd1);
        chk("t5.pend_ara",  bus.mem_araddr,         32'h8000_0004);
        chk("t5.pend_done", 32'(bus.ifu_rsp_valid), 32'd0);
        tick();
        tick();
        chk("t5.pend_inst", bus.ifu_rsp_instr,      32'h2222_2222);
        bus.ifu_rsp_ready = 1'b1;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h8000_000C;
        bus.mem_rdata     = 32'h3333_3333;
        tick();
        bus.ifu_rsp_ready = 1'b0;
        bus.ifu_req_valid = 1'b0;
        chk("t5.b2b_arv",   32'(bus.mem_arvalid),   32'd1);
        chk("t5.b2b_ara",   bus.mem_araddr,         32'h8000_000C);
        chk("t5.b2b_rsp",   32'(bus.ifu_rsp_valid), 32'd0);
        tick();
        tick();
        chk("t5.b2b_inst",  bus.ifu_rsp_instr,      32'h3333_3333);
        chk("t5.b2b_err",   32'(bus.ifu_rsp_err),   32'd0);
        bus.ifu_rsp_ready = 1'b1;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h8000_0001;
        tick();
        bus.ifu_req_valid = 1'b0;
        chk("t5.mis_rsp",   32'(bus.ifu_rsp_valid), 32'd1);
        chk("t5.mis_err",   32'(bus.ifu_rsp_err),   32'd1);
        chk("t5.mis_inst",  bus.ifu_rsp_instr,      32'h0000_0013);
        chk("t5.mis_arv",   32'(bus.mem_arvalid),   32'd0);
        tick();
        bus.ifu_rsp_ready = 1'b0;
        chk("t5.end_rsp",   32'(bus.ifu_rsp_valid), 32'd0);
        chk("t5.end_rdy",   32'(bus.ifu_req_ready), 32'd1);

        // 6: reset during DATA with a read response pending
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = 32'h4444_4444;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h8000_0020;
        tick();
        bus.ifu_req_valid = 1'b0;
        tick();
        chk("t6.rready", 32'(bus.mem_rready), 32'd1);
        rst            = 1'b1;
        bus.mem_rvalid = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("t6");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6.late_rsp", 32'(bus.ifu_rsp_valid), 32'd0);
            chk("t6.late_rrdy", 32'(bus.mem_rready),   32'd0);
        end
        bus.mem_rvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
